// File: rtl/drv_switch_pkg.sv
// Shared types and width helpers for the switch-row event path.
package drv_switch_pkg;

    // Kind of key event carried through the event FIFO.
    typedef enum logic {
        EV_CLICK   = 1'b0,
        EV_RELEASE = 1'b1
    } ev_kind_t;

    // Width of a channel code for n channels; never narrower than one bit.
    function automatic int code_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/drv_switch_event_fifo.sv
// Small first-word-fall-through FIFO: the head entry is always visible on o_data.
module drv_switch_event_fifo #(
    parameter int p_data_w = 3,
    parameter int p_depth  = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  logic [p_data_w-1:0]        i_data,
    input  logic                       i_pop,
    output logic [p_data_w-1:0]        o_data,
    output logic [$clog2(p_depth):0]   o_level,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int addr_w = $clog2(p_depth);
    localparam int lvl_w  = addr_w + 1;

    logic [p_data_w-1:0] mem [p_depth];
    logic [addr_w-1:0]   wr_ptr;
    logic [addr_w-1:0]   rd_ptr;
    logic                do_push;
    logic                do_pop;

    // Push is refused when full and pop is ignored when empty, so the
    // occupancy can never run past its bounds.
    always_comb begin
        do_push = i_push && !o_full;
        do_pop  = i_pop && !o_empty;
    end

    // Storage, wrap-around pointers and occupancy; storage is cleared on reset
    // so the head never shows X.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_level <= '0;
            for (int i = 0; i < p_depth; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= i_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   o_level <= o_level + 1'b1;
                2'b01:   o_level <= o_level - 1'b1;
                default: o_level <= o_level;
            endcase
        end
    end

    // Status flags and head entry, all derived from registered state.
    always_comb begin
        o_full  = (o_level == lvl_w'(p_depth));
        o_empty = (o_level == '0);
        o_data  = mem[rd_ptr];
    end

endmodule

// File: rtl/drv_switch_event_arb.sv
// Serialises per-channel click/release pulses through a round-robin arbiter
// into an event FIFO presented on a valid/ready port.
module drv_switch_event_arb
    import drv_switch_pkg::*;
#(
    parameter  int p_width  = 4,
    parameter  int p_depth  = 4,
    localparam int p_code_w = code_w(p_width)
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [p_width-1:0]         i_click,
    input  logic [p_width-1:0]         i_release,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [p_code_w-1:0]        o_code,
    output logic                       o_kind,
    output logic [$clog2(p_depth):0]   o_level,
    output logic                       o_drop
);

    localparam int n_req   = 2 * p_width;
    localparam int rr_w    = $clog2(n_req);
    localparam int entry_w = p_code_w + 1;

    logic [n_req-1:0]    pend;
    logic [n_req-1:0]    pulse_vec;
    logic [n_req-1:0]    upper;
    logic [n_req-1:0]    search;
    logic [n_req-1:0]    gnt_vec;
    logic                gnt_valid;
    logic [rr_w-1:0]     gnt_idx;
    logic [rr_w-1:0]     next_ptr;
    logic [p_code_w-1:0] gnt_code;
    ev_kind_t            gnt_kind;
    logic [rr_w-1:0]     rr_ptr;
    logic                fifo_full;
    logic                fifo_empty;
    logic [entry_w-1:0]  head;

    // Flatten the two pulse rows so requester r = 2*channel + kind.
    always_comb begin
        pulse_vec = '0;
        for (int ch = 0; ch < p_width; ch++) begin
            pulse_vec[2*ch]   = i_click[ch];
            pulse_vec[2*ch+1] = i_release[ch];
        end
    end

    // Round-robin pick: lowest pending bit at or above the pointer, otherwise
    // wrap to the lowest pending bit overall; nothing is granted while full.
    always_comb begin
        upper = '0;
        for (int i = 0; i < n_req; i++) begin
            upper[i] = pend[i] && (rr_w'(i) >= rr_ptr);
        end
        search    = (|upper) ? upper : pend;
        gnt_valid = (|pend) && !fifo_full;
        gnt_idx   = '0;
        gnt_code  = '0;
        gnt_kind  = EV_CLICK;
        for (int i = n_req - 1; i >= 0; i--) begin
            if (search[i]) begin
                gnt_idx  = rr_w'(i);
                gnt_code = p_code_w'(i / 2);
                gnt_kind = ev_kind_t'(i[0]);
            end
        end
        gnt_vec = '0;
        if (gnt_valid) begin
            gnt_vec[gnt_idx] = 1'b1;
        end
        next_ptr = (gnt_idx == rr_w'(n_req - 1)) ? '0 : gnt_idx + 1'b1;
    end

    // Pending requests, rotating pointer and the one-cycle drop pulse; a pulse
    // arriving on the grant cycle re-arms the request as a fresh event.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            pend   <= '0;
            rr_ptr <= '0;
            o_drop <= 1'b0;
        end else begin
            pend   <= (pend & ~gnt_vec) | pulse_vec;
            o_drop <= |(pulse_vec & pend & ~gnt_vec);
            if (gnt_valid) begin
                rr_ptr <= next_ptr;
            end
        end
    end

    drv_switch_event_fifo #(
        .p_data_w (entry_w),
        .p_depth  (p_depth)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (gnt_valid),
        .i_data  ({gnt_code, gnt_kind}),
        .i_pop   (i_ready),
        .o_data  (head),
        .o_level (o_level),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    // The consumer port is the FIFO head, straight from storage.
    always_comb begin
        o_valid = !fifo_empty;
        o_code  = head[entry_w-1:1];
        o_kind  = head[0];
    end

endmodule

// File: tb/tb_drv_switch_event_arb.sv
// Self-checking bench for drv_switch_event_arb: directed scenarios plus random
// traffic, compared each cycle against a queue-based event model.
module tb_drv_switch_event_arb;

    localparam int W    = 4;
    localparam int D    = 4;
    localparam int NREQ = 2 * W;
    localparam int CW   = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  click = '0;
    logic [W-1:0]  rel = '0;
    logic          ready = 1'b0;
    logic          o_valid;
    logic [CW-1:0] o_code;
    logic          o_kind;
    logic [2:0]    o_level;
    logic          o_drop;

    typedef struct {
        int code;
        int kind;
    } ev_t;

    ev_t q[$];
    bit  m_pend[NREQ];
    int  m_rr;
    bit  m_drop;
    int  vectors = 0;
    int  miscompares = 0;

    drv_switch_event_arb #(
        .p_width (W),
        .p_depth (D)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst_n),
        .i_click   (click),
        .i_release (rel),
        .o_valid   (o_valid),
        .i_ready   (ready),
        .o_code    (o_code),
        .o_kind    (o_kind),
        .o_level   (o_level),
        .o_drop    (o_drop)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic model_reset();
        q.delete();
        for (int r = 0; r < NREQ; r++) m_pend[r] = 1'b0;
        m_rr   = 0;
        m_drop = 1'b0;
    endtask

    // One clock edge of the reference behaviour, using the inputs now driven.
    task automatic model_step();
        int  g;
        bit  full;
        bit  pulse;
        bit  nd;
        bit  np[NREQ];
        full = (q.size() == D);
        g = -1;
        if (!full) begin
            for (int k = 0; k < NREQ; k++) begin
                int r;
                r = (m_rr + k) % NREQ;
                if (g < 0 && m_pend[r]) g = r;
            end
        end
        if (ready && q.size() > 0) void'(q.pop_front());
        if (g >= 0) begin
            ev_t e;
            e.code = g / 2;
            e.kind = g % 2;
            q.push_back(e);
            m_rr = (g + 1) % NREQ;
        end
        nd = 1'b0;
        for (int r = 0; r < NREQ; r++) begin
            pulse = (r % 2 == 1) ? rel[r/2] : click[r/2];
            if (pulse && m_pend[r] && r != g) nd = 1'b1;
            np[r] = pulse || (m_pend[r] && r != g);
        end
        for (int r = 0; r < NREQ; r++) m_pend[r] = np[r];
        m_drop = nd;
    endtask

    task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic checkOutput();
        int exp_level;
        bit exp_valid;
        exp_level = q.size();
        exp_valid = (q.size() > 0);
        vectors++;
        assert (o_valid === exp_valid) else begin
            miscompares++;
            $error("[TB] FAIL valid @%0t: got %b expected %b", $time, o_valid, exp_valid);
        end
        vectors++;
        assert (o_level === 3'(exp_level)) else begin
            miscompares++;
            $error("[TB] FAIL level @%0t: got %0d expected %0d", $time, o_level, exp_level);
        end
        vectors++;
        assert (o_drop === m_drop) else begin
            miscompares++;
            $error("[TB] FAIL drop @%0t: got %b expected %b", $time, o_drop, m_drop);
        end
        if (exp_valid) begin
            vectors++;
            assert (o_code === CW'(q[0].code)) else begin
                miscompares++;
                $error("[TB] FAIL code @%0t: got %0d expected %0d", $time, o_code, q[0].code);
            end
            vectors++;
            assert (o_kind === 1'(q[0].kind)) else begin
                miscompares++;
                $error("[TB] FAIL kind @%0t: got %b expected %0d", $time, o_kind, q[0].kind);
            end
        end
    endtask

    task automatic applyStimulus(input logic [W-1:0] c, input logic [W-1:0] r, input logic rd);
        @(negedge clk);
        checkOutput();
        click = c;
        rel   = r;
        ready = rd;
        model_step();
    endtask

    task automatic doReset();
        @(negedge clk);
        checkOutput();
        click = '0;
        rel   = '0;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        checkValue("rst_valid", 32'(o_valid), 32'd0);
        checkValue("rst_level", 32'(o_level), 32'd0);
        checkValue("rst_drop",  32'(o_drop),  32'd0);
        checkValue("rst_code",  32'(o_code),  32'd0);
        checkValue("rst_kind",  32'(o_kind),  32'd0);
        rst_n = 1'b1;

        // Single click on channel 2.
        repeat (5) applyStimulus('0, '0, 1'b1);
        applyStimulus(4'b0100, '0, 1'b1);
        applyStimulus('0, '0, 1'b1);
        applyStimulus('0, '0, 1'b1);
        checkValue("single_valid", 32'(o_valid), 32'd1);
        checkValue("single_code",  32'(o_code),  32'd2);
        checkValue("single_kind",  32'(o_kind),  32'd0);
        repeat (3) applyStimulus('0, '0, 1'b1);

        // Three simultaneous events from the reset pointer.
        doReset();
        applyStimulus(4'b1001, 4'b0010, 1'b1);
        applyStimulus('0, '0, 1'b1);
        applyStimulus('0, '0, 1'b1);
        checkValue("simul0_code", 32'(o_code), 32'd0);
        checkValue("simul0_kind", 32'(o_kind), 32'd0);
        applyStimulus('0, '0, 1'b1);
        checkValue("simul1_code", 32'(o_code), 32'd1);
        checkValue("simul1_kind", 32'(o_kind), 32'd1);
        applyStimulus('0, '0, 1'b1);
        checkValue("simul2_code", 32'(o_code), 32'd3);
        checkValue("simul2_kind", 32'(o_kind), 32'd0);
        repeat (4) applyStimulus('0, '0, 1'b1);

        // Fairness under back-pressure with repeated pulses on ch0/ch1.
        applyStimulus(4'b1111, '0, 1'b0);
        repeat (4) applyStimulus('0, '0, 1'b0);
        repeat (6) applyStimulus(4'b0011, '0, 1'b0);
        repeat (12) applyStimulus(4'b0011, '0, 1'b1);
        repeat (8) applyStimulus('0, '0, 1'b1);

        // Full boundary: five events into a depth-4 FIFO.
        applyStimulus(4'b1111, 4'b0001, 1'b0);
        repeat (6) applyStimulus('0, '0, 1'b0);
        checkValue("full_level", 32'(o_level), 32'd4);
        applyStimulus('0, '0, 1'b1);
        applyStimulus('0, '0, 1'b0);
        applyStimulus('0, '0, 1'b0);
        checkValue("refill_level", 32'(o_level), 32'd4);
        checkValue("refill_drop",  32'(o_drop),  32'd0);
        repeat (8) applyStimulus('0, '0, 1'b1);

        // Eight-event stream with ready toggling.
        applyStimulus(4'b1111, '0, 1'b1);
        applyStimulus('0, 4'b1111, 1'b1);
        for (int i = 0; i < 20; i++) applyStimulus('0, '0, (i % 2 == 0));
        repeat (6) applyStimulus('0, '0, 1'b1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(W'($urandom & $urandom), W'($urandom & $urandom),
                          ($urandom_range(0, 3) != 0));
        end
        repeat (12) applyStimulus('0, '0, 1'b1);

        // Reset mid-operation with three queued events and one pending.
        applyStimulus(4'b0111, '0, 1'b0);
        repeat (3) applyStimulus('0, '0, 1'b0);
        applyStimulus('0, 4'b0001, 1'b0);
        @(negedge clk);
        checkOutput();
        checkValue("pre_rst_level", 32'(o_level), 32'd3);
        click = '0;
        rel   = '0;
        #1 rst_n = 1'b0;
        #1;
        checkValue("mid_rst_valid", 32'(o_valid), 32'd0);
        checkValue("mid_rst_level", 32'(o_level), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) applyStimulus('0, '0, 1'b1);
        @(negedge clk);
        checkOutput();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
